uart_word_loader: RTL
=====================

// Module: uart_word_loader
// PURPOSE
//  Parametrised UART receiver that assembles serial bytes into memory words for the
//  instruction/data loader. Fully synchronous on clk: no async edges on uart_rx or
//  internal strobes. Adds start-bit glitch rejection, optional parity, framing/parity
//  error flags, configurable word size, and address restart. Output feeds the
//  instruction-memory write port (buffer, data_addr, uart_done).
// PARAMETERS
//  CLK_DIV        5208  clk cycles per bit (50 MHz / 9600 baud); must be >= 4
//  DATA_BITS      8     data bits per frame, 5..8, sent LSB first
//  PARITY_EN      0     1 = one parity bit follows the data bits
//  PARITY_ODD     0     with PARITY_EN: 0 = even parity, 1 = odd parity
//  BYTES_PER_WORD 4     bytes packed per output word, 1..4
//  ADDR_W         16    width of data_addr
//  ADDR_STEP      4     data_addr increment per completed word
// PORTS
//  clk        in  1                  system clock
//  rst_p      in  1                  synchronous reset, active-high
//  uart_rx    in  1                  serial line, idle high, asynchronous to clk
//  clr        in  1                  sync restart: byte lane and data_addr -> 0, abort frame
//  uart_done  out 1                  1-cycle pulse: buffer/data_addr hold a complete word
//  buffer     out 8*BYTES_PER_WORD   assembled word, first received byte in bits [7:0]
//  data_addr  out ADDR_W             target address of the word in buffer
//  frame_err  out 1                  1-cycle pulse: stop bit sampled low
//  parity_err out 1                  1-cycle pulse: parity mismatch
//  busy       out 1                  high while FSM is not IDLE
// BEHAVIOUR
//  - Reset (rst_p=1 at posedge clk): all outputs 0, FSM IDLE, byte lane 0, bit and baud
//    counters 0, both synchroniser flops 1. rst_p has priority over clr.
//  - uart_rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
//  - Baud counter runs 0..CLK_DIV-1 outside IDLE. The mid-bit sample point is
//    count == CLK_DIV/2-1 in START and count == CLK_DIV-1 in later states.
//  - FSM states:
//    - IDLE: a 1->0 transition on rx_s moves to START with count = 0.
//    - START: at the half-bit point, rx_s==0 -> DATA and count restarts. rx_s==1 ->
//      IDLE (glitch, no flags).
//    - DATA: DATA_BITS samples, shifted LSB first. After the last sample go to PARITY
//      if PARITY_EN, else STOP.
//    - PARITY: sample one bit and compare against the XOR of the data, inverted when
//      PARITY_ODD=1. Go to STOP.
//    - STOP: sample one bit, then always return to IDLE.
//      - Stop bit 1 and parity good: byte accepted.
//      - Stop bit 0: frame_err pulse, byte discarded.
//      - Parity bad: parity_err pulse, byte discarded.
//      - Stop bit 0 and parity bad together: both pulses fire.
//      - IDLE waits for a fresh 1->0 transition, so a held-low line never retriggers.
//  - Accepted byte: written to lane[byte_idx]. Data sits in the low DATA_BITS bits;
//    upper lane bits are 0.
//    - byte_idx < BYTES_PER_WORD-1: byte_idx increments.
//    - byte_idx == BYTES_PER_WORD-1: byte_idx wraps to 0. On the next cycle buffer
//      loads the full word and uart_done pulses for exactly 1 cycle.
//  - buffer changes only on word completion and stays stable between uart_done pulses.
//  - data_addr is valid during uart_done. It increments by ADDR_STEP on the cycle after
//    uart_done and wraps modulo 2^ADDR_W. The first word goes to address 0.
//  - Error pulses are asserted the cycle after the stop sample. Discarded bytes leave
//    byte_idx and data_addr unchanged.
//  - clr: FSM -> IDLE, byte_idx -> 0, data_addr -> 0. Partial bytes are lost.
//    buffer is retained. clr during the uart_done cycle suppresses that cycle's
//    address increment.
//  - Latency: uart_done rises (1+DATA_BITS+PARITY_EN)*CLK_DIV + CLK_DIV/2 + 3 cycles
//    (+/-1) after the start-bit falling edge of the last byte.
// TESTING  (bench with CLK_DIV=16 unless noted)
//  - Send 0x13,0x05,0x00,0x00 -> one uart_done pulse, buffer=0x00000513, data_addr=0;
//    next 4 bytes -> data_addr=4.
//  - Drive uart_rx low for 4 cycles, then high -> no state change beyond START,
//    no pulses, busy returns to 0 within CLK_DIV/2+3 cycles.
//  - Send 0xA5 with stop bit 0 -> frame_err pulse. The following 4 good bytes form a
//    word with 0xA5 absent.
//  - PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity 0 -> parity_err. With parity 1
//    -> byte accepted.
//  - Assert rst_p mid-DATA of byte 2 -> all outputs 0. The next 4 bytes form a word
//    at data_addr=0.
//  - ADDR_W=4, BYTES_PER_WORD=1: send 5 bytes -> data_addr 0,4,8,C,0. Pulse clr after
//    byte 2 -> next word at address 0.

Source files
------------

// File: rtl/uart_word_loader.sv
// -----------------------------------------------------------------------------
// uart_word_loader
//   UART receiver that packs serial bytes into memory words for the
//   instruction/data loader. Everything runs on clk. The raw line is brought in
//   through a two-flop synchroniser, and all bit sampling uses the synchronised
//   copy. A start bit that is gone by its mid-point is treated as a glitch and
//   dropped. Each frame can optionally carry a parity bit. A frame with a bad
//   stop bit or bad parity is flagged and discarded. Good bytes fill the lanes
//   of a word. When the last lane is written, the whole word is published on
//   buffer with a one-cycle uart_done strobe.
//
// Ports
//   clk         in   system clock
//   rst_p       in   synchronous reset, active-high (has priority over clr)
//   uart_rx     in   serial line, idle high, asynchronous to clk
//   clr         in   synchronous restart: abort frame, byte lane and data_addr -> 0
//   uart_done   out  1-cycle strobe: buffer/data_addr hold a complete word
//   buffer      out  assembled word, first received byte in bits [7:0]
//   data_addr   out  target address of the word in buffer
//   frame_err   out  1-cycle strobe: stop bit sampled low
//   parity_err  out  1-cycle strobe: parity mismatch
//   busy        out  high while a frame is being received
// -----------------------------------------------------------------------------
module uart_word_loader #(
    parameter int CLK_DIV        = 5208,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_EN      = 0,
    parameter int PARITY_ODD     = 0,
    parameter int BYTES_PER_WORD = 4,
    parameter int ADDR_W         = 16,
    parameter int ADDR_STEP      = 4
) (
    input  logic                        clk,
    input  logic                        rst_p,
    input  logic                        uart_rx,
    input  logic                        clr,
    output logic                        uart_done,
    output logic [8*BYTES_PER_WORD-1:0] buffer,
    output logic [ADDR_W-1:0]           data_addr,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        busy
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state, state_nx;

    logic                            rx_meta, rx_s, rx_prev;
    logic [CNT_W-1:0]                baud_cnt;
    logic [2:0]                      bit_cnt;
    logic [DATA_BITS-1:0]            shreg;
    logic                            par_bad;
    logic [IDX_W-1:0]                byte_idx;
    logic [BYTES_PER_WORD-1:0][7:0]  lanes;
    logic                            word_ready;

    logic sample;       // mid-bit sample point in the current state
    logic stop_sample;  // the stop bit is being sampled now
    logic accept;       // the frame just ended cleanly

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state is updated with <= so that every flop samples
    // values from before the edge, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst_p) state <= S_IDLE;
        else       state <= state_nx;
    end

    // ------------------------------------------------------------------
    // Next-state and sample-point decode
    // ------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        sample   = 1'b0;
        unique case (state)
            S_IDLE: begin
                // Only a fresh 1->0 edge starts a frame, so a line held low
                // after a framing error cannot retrigger the receiver.
                if (rx_prev && !rx_s) state_nx = S_START;
            end
            S_START: begin
                if (baud_cnt == HALF_LAST) begin
                    sample   = 1'b1;
                    state_nx = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (baud_cnt == FULL_LAST) begin
                    sample = 1'b1;
                    if (bit_cnt == LAST_BIT)
                        state_nx = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (baud_cnt == FULL_LAST) begin
                    sample   = 1'b1;
                    state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_cnt == FULL_LAST) begin
                    sample   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (clr) state_nx = S_IDLE;
    end

    assign stop_sample = (state == S_STOP) && sample && !clr;
    assign accept      = stop_sample && rx_s && !par_bad;
    assign busy        = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Synchroniser, counters, receive datapath and word output
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_p) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            byte_idx   <= '0;
            word_ready <= 1'b0;
            uart_done  <= 1'b0;
            buffer     <= '0;
            data_addr  <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;

            // The counter restarts at every sample point. It therefore wraps
            // at CLK_DIV-1 inside a bit period, and the half-bit start
            // sample puts the later samples in the middle of each bit.
            if (state == S_IDLE || state_nx == S_IDLE || sample) baud_cnt <= '0;
            else                                                  baud_cnt <= baud_cnt + 1'b1;

            if (state != S_DATA || state_nx != S_DATA) bit_cnt <= '0;
            else if (sample)                           bit_cnt <= bit_cnt + 3'd1;

            // Shifting in from the top leaves the first (LSB) bit at bit 0.
            if (state == S_DATA && sample)
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};

            if (state == S_START)
                par_bad <= 1'b0;
            else if (state == S_PARITY && sample)
                par_bad <= (rx_s != ((^shreg) ^ ODD));

            frame_err  <= stop_sample && !rx_s;
            parity_err <= stop_sample && par_bad;

            if (clr)
                byte_idx <= '0;
            else if (accept)
                byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;

            // The last lane lands on this edge. Publishing one cycle later
            // lets buffer take the completed lane array.
            word_ready <= accept && (byte_idx == LAST_IDX);
            uart_done  <= word_ready && !clr;
            if (word_ready && !clr)
                buffer <= lanes;

            // The address stays valid during uart_done and advances just after.
            if (clr)
                data_addr <= '0;
            else if (uart_done)
                data_addr <= data_addr + ADDR_W'(ADDR_STEP);
        end
    end

    // NOTE: the lane storage has no reset. byte_idx restarts at 0 after
    // reset or clr, so every lane is rewritten before a word is published.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (byte_idx == IDX_W'(i))
                    lanes[i] <= 8'(shreg);
            end
        end
    end

endmodule
